// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock.
package lock_pkg;
  localparam int DIGIT_W = 4;
  localparam int COUNT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } lock_state_t;
endpackage

// File: rtl/lock_entry_buffer.sv
// Keypad digit shift register and digit counter; first digit ends up in the MS nibble.
// Clear has priority over accept; both take effect on the next clock.
module lock_entry_buffer
  import lock_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        accept,
  input  logic                        clear,
  input  logic [DIGIT_W-1:0]          digit,
  output logic [DIGIT_W*CODE_LEN-1:0] entry,
  output logic [COUNT_W-1:0]          count,
  output logic                        full
);
  localparam int EW = DIGIT_W * CODE_LEN;

  logic [EW-1:0]      entry_q, entry_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (clear) begin
      entry_d = '0;
      count_d = '0;
    end else if (accept) begin
      entry_d = (entry_q << DIGIT_W) | EW'(digit);
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign entry = entry_q;
  assign count = count_q;
  assign full  = (count_q == COUNT_W'(CODE_LEN));
endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: code entry, try counting, lockout via external rate_divider timer.
// All outputs registered. Optional LOCK_AUTO_RELOCK_EN reuses the timer to re-lock after opening.
module lock_controller
  import lock_pkg::*;
#(
  parameter int                        CODE_LEN  = 4,
  parameter int                        MAX_TRIES = 3,
  parameter logic [DIGIT_W*CODE_LEN-1:0] SECRET  = 16'h1234
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_digit,
  input  logic                           key_clear,
  input  logic                           lock_cmd,
  input  logic                           end_sleep,
  output logic                           sleep,
  output logic                           unlocked,
  output logic                           lockout,
  output logic                           fail_pulse,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [COUNT_W-1:0]             digit_count
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  lock_state_t state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic sleep_q, sleep_d, unlocked_q, unlocked_d;
  logic lockout_q, lockout_d, fail_q, fail_d;

  logic                        accept, clear, full, match, timer_done;
  logic [DIGIT_W*CODE_LEN-1:0] entry;
  logic [COUNT_W-1:0]          count;

  assign accept = (state_q == ST_LOCKED) && key_valid && !key_clear && (key_digit <= MAX_DIGIT);
  assign clear  = ((state_q == ST_LOCKED) && key_clear) || (state_q == ST_CHECK);
  assign match  = full && (entry == SECRET);
  // A held-over end_sleep from the previous run is only honoured while we drive sleep.
  assign timer_done = end_sleep && sleep_q;

  lock_entry_buffer #(.CODE_LEN(CODE_LEN)) u_entry (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .clear  (clear),
    .digit  (key_digit),
    .entry  (entry),
    .count  (count),
    .full   (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOCKED;
      tries_q    <= TW'(MAX_TRIES);
      sleep_q    <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      sleep_q    <= sleep_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCKED: begin
        if (accept && (count == COUNT_W'(CODE_LEN - 1))) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (match)                  state_d = ST_OPEN;
        else if (tries_q == TW'(1)) state_d = ST_LOCKOUT;
        else                        state_d = ST_LOCKED;
      end
      ST_OPEN: begin
`ifdef LOCK_AUTO_RELOCK_EN
        if (lock_cmd || timer_done) state_d = ST_LOCKED;
`else
        if (lock_cmd) state_d = ST_LOCKED;
`endif
      end
      ST_LOCKOUT: begin
        if (timer_done) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
    lockout_d  = (state_d == ST_LOCKOUT);
`ifdef LOCK_AUTO_RELOCK_EN
    sleep_d    = lockout_d || unlocked_d;
`else
    sleep_d    = lockout_d;
`endif
    fail_d     = (state_q == ST_CHECK) && !match;
    tries_d    = tries_q;
    if (state_q == ST_CHECK) begin
      tries_d = match ? TW'(MAX_TRIES) : (tries_q - 1'b1);
    end else if ((state_q == ST_LOCKOUT) && timer_done) begin
      tries_d = TW'(MAX_TRIES);
    end
  end

  assign sleep       = sleep_q;
  assign unlocked    = unlocked_q;
  assign lockout     = lockout_q;
  assign fail_pulse  = fail_q;
  assign tries_left  = tries_q;
  assign digit_count = count;
endmodule
